// File: rtl/axi4_bram_slave.sv
`default_nettype none
// =============================================================================
// axi4_bram_slave : AXI4 slave over a simple dual-port RAM (FIXED/INCR/WRAP,
//                   byte strobes, backpressure, SLVERR).   Rev 1.0
// =============================================================================
module axi4_bram_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 7,
    parameter int DEPTH  = 1024
) (
    input  logic                s_aclk,
    input  logic                s_aresetn,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int         STRB_W      = DATA_W / 8;
    localparam int         LSB         = $clog2(STRB_W);
    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [2:0] MAX_SIZE    = 3'(LSB);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        inc  = addr + (ADDR_W'(1) << size);
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | (inc & mask);
            default:     next_addr = inc;
        endcase
    endfunction

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        out_of_range = (addr >> LSB) >= ADDR_W'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        word_idx = IDX_W'(addr >> LSB);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------------------------------------------------------- write
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    wstate_t           wstate_q, wstate_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]        wsize_q, wsize_d;
    logic [1:0]        wburst_q, wburst_d, bresp_q, bresp_d;
    logic              werr_q, werr_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic              w_beat_err, w_we;

    always_comb begin
        wstate_d   = wstate_q;
        wid_d      = wid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        wsize_d    = wsize_q;
        wburst_d   = wburst_q;
        werr_d     = werr_q;
        bresp_d    = bresp_q;
        w_beat_err = (wsize_q > MAX_SIZE) || (wburst_q == BURST_RSVD) || out_of_range(waddr_q);
        w_we       = (wstate_q == W_DATA) && wready_q && s_axi_wvalid && !w_beat_err;
        case (wstate_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    wid_d    = s_axi_awid;
                    waddr_d  = s_axi_awaddr;
                    wlen_d   = s_axi_awlen;
                    wsize_d  = s_axi_awsize;
                    wburst_d = s_axi_awburst;
                    wcnt_d   = 8'd0;
                    werr_d   = 1'b0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && wready_q) begin
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    // A misplaced wlast poisons the response but does not end the burst early.
                    werr_d  = werr_q || w_beat_err || (s_axi_wlast != (wcnt_q == wlen_q));
                    if (wcnt_q == wlen_q) begin
                        wstate_d = W_RESP;
                        bresp_d  = werr_d ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready && bvalid_q) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
        awready_d = (wstate_d == W_IDLE);
        wready_d  = (wstate_d == W_DATA);
        bvalid_d  = (wstate_d == W_RESP);
    end

    always_ff @(posedge s_aclk) begin
        if (!s_aresetn) begin
            wstate_q  <= W_IDLE;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    always_ff @(posedge s_aclk) begin
        if (s_aresetn && w_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------------------------------------------------------- read
    typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} rstate_t;
    rstate_t           rstate_q, rstate_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [1:0]        rburst_q, rburst_d;
    logic              rdone_q, rdone_d, arready_q, arready_d;
    logic              out_v_q, out_v_d, out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic [1:0]        out_resp_q, out_resp_d, skid_resp_q, skid_resp_d;
    logic              skid_v_q, skid_v_d, skid_last_q, skid_last_d;
    logic              r_issue, r_pop, r_err, r_last;
    logic [DATA_W-1:0] r_data;

    always_comb begin
        rstate_d    = rstate_q;
        rid_d       = rid_q;
        raddr_d     = raddr_q;
        rlen_d      = rlen_q;
        rcnt_d      = rcnt_q;
        rsize_d     = rsize_q;
        rburst_d    = rburst_q;
        rdone_d     = rdone_q;
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        out_resp_d  = out_resp_q;
        out_last_d  = out_last_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_resp_d = skid_resp_q;
        skid_last_d = skid_last_q;
        // Issue depends only on registered state, so rready never reaches the RAM address.
        r_issue = (rstate_q == R_BURST) && !rdone_q && !skid_v_q;
        r_pop   = out_v_q && s_axi_rready;
        r_err   = (rsize_q > MAX_SIZE) || (rburst_q == BURST_RSVD) || out_of_range(raddr_q);
        r_data  = r_err ? '0 : mem[word_idx(raddr_q)];
        r_last  = (rcnt_q == rlen_q);
        case (rstate_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    rid_d    = s_axi_arid;
                    raddr_d  = s_axi_araddr;
                    rlen_d   = s_axi_arlen;
                    rsize_d  = s_axi_arsize;
                    rburst_d = s_axi_arburst;
                    rcnt_d   = 8'd0;
                    rdone_d  = 1'b0;
                    rstate_d = R_BURST;
                end
            end
            R_BURST: begin
                if (r_issue) begin
                    raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                    if (r_last) rdone_d = 1'b1;
                    else        rcnt_d  = rcnt_q + 8'd1;
                end
                if (r_pop && out_last_q) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
        if (!out_v_q || r_pop) begin
            if (out_v_q && skid_v_q) begin
                out_data_d = skid_data_q;
                out_resp_d = skid_resp_q;
                out_last_d = skid_last_q;
                skid_v_d   = 1'b0;
            end else if (r_issue) begin
                out_v_d    = 1'b1;
                out_data_d = r_data;
                out_resp_d = r_err ? RESP_SLVERR : RESP_OKAY;
                out_last_d = r_last;
            end else begin
                out_v_d    = 1'b0;
                out_last_d = 1'b0;
            end
        end else if (r_issue) begin
            skid_v_d    = 1'b1;
            skid_data_d = r_data;
            skid_resp_d = r_err ? RESP_SLVERR : RESP_OKAY;
            skid_last_d = r_last;
        end
        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge s_aclk) begin
        if (!s_aresetn) begin
            rstate_q    <= R_IDLE;
            rid_q       <= '0;
            raddr_q     <= '0;
            rlen_q      <= '0;
            rcnt_q      <= '0;
            rsize_q     <= '0;
            rburst_q    <= '0;
            rdone_q     <= 1'b0;
            arready_q   <= 1'b1;
            out_v_q     <= 1'b0;
            out_data_q  <= '0;
            out_resp_q  <= RESP_OKAY;
            out_last_q  <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_resp_q <= RESP_OKAY;
            skid_last_q <= 1'b0;
        end else begin
            rstate_q    <= rstate_d;
            rid_q       <= rid_d;
            raddr_q     <= raddr_d;
            rlen_q      <= rlen_d;
            rcnt_q      <= rcnt_d;
            rsize_q     <= rsize_d;
            rburst_q    <= rburst_d;
            rdone_q     <= rdone_d;
            arready_q   <= arready_d;
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            out_resp_q  <= out_resp_d;
            out_last_q  <= out_last_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_resp_q <= skid_resp_d;
            skid_last_q <= skid_last_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = wid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = out_v_q;
    assign s_axi_rdata   = out_data_q;
    assign s_axi_rresp   = out_resp_q;
    assign s_axi_rlast   = out_last_q;
    assign s_axi_rid     = rid_q;

endmodule
`default_nettype wire
